key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Multi-channel push-button conditioner: synchronises raw board keys, samples them on a
//  slow prescaled tick and accepts a new level only after STABLE_SAMPLES consecutive equal
//  samples. Sits directly upstream of the edge-to-single-pulse stage, whose in_trig inputs
//  take key_db. key_changed is a per-key one-cycle change flag for status/LED logic.
// PARAMETERS
//  N_KEYS          4       number of independent key channels (>=1)
//  CLK_DIV         100000  clk cycles per sample tick (1 ms at 100 MHz); >=1
//  STABLE_SAMPLES  4       consecutive differing ticks required to accept a new level; >=1
//  ACTIVE_LOW      0       1: raw key is inverted before synchronisation (pressed = 0 on pin)
// PORTS
//  clk          in   1       system clock; all state on posedge clk
//  rst_n        in   1       asynchronous, active-low reset
//  key_raw      in   N_KEYS  raw asynchronous key pins
//  key_db       out  N_KEYS  debounced level, 1 = pressed (after ACTIVE_LOW polarity)
//  key_changed  out  N_KEYS  1-cycle pulse on the edge where key_db[i] toggles
//  sample_tick  out  1       1-cycle strobe, prescaler terminal count
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync flops, prescaler, all stability counters, key_db,
//    key_changed, sample_tick -> 0. Sync flops hold post-polarity value, so 0 = released.
//  - Sync: key_raw (XOR ACTIVE_LOW) through 2 flops per channel -> key_s. No other
//    logic touches key_raw.
//  - Prescaler: div_cnt width $clog2(CLK_DIV) (min 1); counts 0..CLK_DIV-1, wraps to 0.
//    sample_tick registered, high in the cycle after div_cnt==CLK_DIV-1, i.e. exactly
//    once every CLK_DIV cycles. CLK_DIV=1 -> sample_tick high every cycle after reset.
//  - Per channel, only on cycles with sample_tick=1:
//      key_s == key_db[i]            -> cnt <= 0 (any agreeing sample aborts the attempt)
//      key_s != key_db[i], cnt <  STABLE_SAMPLES-1 -> cnt <= cnt+1
//      key_s != key_db[i], cnt == STABLE_SAMPLES-1 -> key_db[i] <= key_s, cnt <= 0,
//                                                     key_changed[i] <= 1
//    cnt width $clog2(STABLE_SAMPLES) (min 1); never exceeds STABLE_SAMPLES-1.
//  - key_changed[i] is 0 in every other cycle; it rises on the same edge as key_db[i].
//  - Latency: a clean level change is accepted on the STABLE_SAMPLES-th tick whose sampled
//    key_s differs; worst case 2 + STABLE_SAMPLES*CLK_DIV clk cycles from the pin edge.
//  - Glitches entirely between two ticks are invisible. Glitches spanning a tick that
//    return before acceptance leave key_db unchanged and reset cnt.
//  - Channels are fully independent; simultaneous acceptances on several channels update
//    the same cycle with multiple key_changed bits set.
//  - Reset mid-count discards partial progress; after release a full STABLE_SAMPLES run
//    is required again. A key held pressed through reset is re-accepted normally.
//  - STABLE_SAMPLES=1: level accepted on the first differing tick.
// STRUCTURE
//  - Shared package/header: board constants CLK_FREQ_HZ=100_000_000 and
//    DEBOUNCE_MS=1, from which the default CLK_DIV is derived; no typedefs required.
//  - Sub-module debounce_channel (2-flop sync, cnt, key_db, key_changed for one key),
//    instantiated N_KEYS times via generate; prescaler lives in key_debounce and feeds
//    sample_tick to every channel.
// TESTING  (bench params: N_KEYS=2, CLK_DIV=4, STABLE_SAMPLES=3, ACTIVE_LOW=0 unless noted)
//  1 Reset: rst_n=0 for 5 cycles with key_raw=2'b11 -> key_db=00, key_changed=00,
//    sample_tick=0 throughout; first sample_tick exactly 4 cycles after rst_n rises.
//  2 Clean press ch0: key_raw 00->01 held -> key_db=01 on the 3rd tick sampling key_s=1,
//    key_changed=01 for exactly that one cycle; ch1 stays 0, no further pulses.
//  3 Bounce: ch0 toggles every 5 clks for 40 clks, then held 1 -> key_db[0] unchanged
//    during bounce; rises only after 3 consecutive ticks of 1; exactly one key_changed pulse.
//  4 ACTIVE_LOW=1: pins 2'b11 at reset -> key_db=00; pin0 driven 0 held -> key_db=01 after
//    3 ticks; pin0 back to 1 held -> key_db=00 after 3 ticks, key_changed pulse each time.
//  5 Reset mid-count: ch0 pressed, rst_n pulsed low after 2 differing ticks -> all outputs 0;
//    after release, key_db[0] rises only after 3 fresh ticks (checker counts ticks).
//  6 Simultaneous: key_raw 00->11 in one cycle, held -> key_db 00->11 on the same edge,
//    key_changed=2'b11 for one cycle; then 11->00 -> mirror result.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// Board-level constants shared by the key conditioning blocks.
// The default prescale gives one sample tick per DEBOUNCE_MS.
package key_debounce_pkg;

    localparam int CLK_FREQ_HZ     = 100_000_000;
    localparam int DEBOUNCE_MS     = 1;
    localparam int DEFAULT_CLK_DIV = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: two-flop synchroniser, stability counter and accepted level.
// Advances only on cycles where the shared sample_tick strobe is high.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int STABLE_SAMPLES = 4,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic sample_tick,
    output logic key_db,
    output logic key_changed
);

    localparam int                CNT_W    = width_of(STABLE_SAMPLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic              POLARITY = (ACTIVE_LOW != 0);

    logic             sync1;
    logic             key_s;
    logic [CNT_W-1:0] cnt;

    // Polarity is folded in before the first flop so reset means "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            key_s <= 1'b0;
        end else begin
            sync1 <= key_raw ^ POLARITY;
            key_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            key_db      <= 1'b0;
            key_changed <= 1'b0;
        end else begin
            key_changed <= 1'b0;
            if (sample_tick) begin
                // Any sample agreeing with the current level aborts the attempt.
                if (key_s == key_db) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    key_db      <= key_s;
                    key_changed <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one shared sample prescaler feeding N_KEYS
// independent debounce_channel instances.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int N_KEYS         = 4,
    parameter int CLK_DIV        = DEFAULT_CLK_DIV,
    parameter int STABLE_SAMPLES = 4,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_db,
    output logic [N_KEYS-1:0] key_changed,
    output logic              sample_tick
);

    localparam int               DIV_W    = width_of(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // The strobe is registered, so it appears the cycle after terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_raw    (key_raw[i]),
            .sample_tick(sample_tick),
            .key_db     (key_db[i]),
            .key_changed(key_changed[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: N_KEYS=2, CLK_DIV=4, STABLE_SAMPLES=3,
// with a second instance built for active-low pins.
module tb_key_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_raw;
    logic [1:0] key_db;
    logic [1:0] key_changed;
    logic       sample_tick;
    logic [1:0] key_raw_al;
    logic [1:0] key_db_al;
    logic [1:0] key_changed_al;
    logic       sample_tick_al;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .N_KEYS(2), .CLK_DIV(4), .STABLE_SAMPLES(3), .ACTIVE_LOW(0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw),
        .key_db     (key_db),
        .key_changed(key_changed),
        .sample_tick(sample_tick)
    );

    key_debounce #(
        .N_KEYS(2), .CLK_DIV(4), .STABLE_SAMPLES(3), .ACTIVE_LOW(1)
    ) dut_al (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_raw    (key_raw_al),
        .key_db     (key_db_al),
        .key_changed(key_changed_al),
        .sample_tick(sample_tick_al)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] raw;
        logic       tick;
        logic [1:0] db;
        logic [1:0] chg;
    } vec_t;

    vec_t vecs[20];

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] raw, input logic [1:0] raw_al);
        key_raw    = raw;
        key_raw_al = raw_al;
    endtask

    // Advance one clock and settle away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_db"},      key_db,               2'b00);
        checkOutput({tag, "_chg"},     key_changed,          2'b00);
        checkOutput({tag, "_tick"},    {1'b0, sample_tick},  2'b00);
        checkOutput({tag, "_al_db"},   key_db_al,            2'b00);
        checkOutput({tag, "_al_chg"},  key_changed_al,       2'b00);
    endtask

    // Asserts reset right now (checking it takes effect before any edge),
    // holds it, then releases with the given pin values.
    task automatic doReset(input int cycles, input logic [1:0] raw, input logic [1:0] raw_al);
        rst_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        for (int c = 0; c < cycles; c++) step();
        applyStimulus(raw, raw_al);
        rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        int ticks;
        int cycles;
        logic [1:0] exp_db;
        logic [1:0] exp_chg;

        // Clean press on ch0 straight out of reset: ticks act on edges 5, 9, 13.
        vecs[0]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{2'b01, 1'b1, 2'b00, 2'b00};
        vecs[4]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[6]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[7]  = '{2'b01, 1'b1, 2'b00, 2'b00};
        vecs[8]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[9]  = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[10] = '{2'b01, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{2'b01, 1'b1, 2'b00, 2'b00};
        vecs[12] = '{2'b01, 1'b0, 2'b01, 2'b01};
        vecs[13] = '{2'b01, 1'b0, 2'b01, 2'b00};
        vecs[14] = '{2'b01, 1'b0, 2'b01, 2'b00};
        vecs[15] = '{2'b01, 1'b1, 2'b01, 2'b00};
        vecs[16] = '{2'b01, 1'b0, 2'b01, 2'b00};
        vecs[17] = '{2'b01, 1'b0, 2'b01, 2'b00};
        vecs[18] = '{2'b01, 1'b0, 2'b01, 2'b00};
        vecs[19] = '{2'b01, 1'b1, 2'b01, 2'b00};

        // Reset held with both keys pressed on the pins.
        rst_n = 1'b0;
        applyStimulus(2'b11, 2'b11);
        for (int c = 0; c < 5; c++) begin
            step();
            checkAllZero("reset");
        end
        applyStimulus(vecs[0].raw, 2'b11);
        rst_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            applyStimulus(vecs[k].raw, 2'b11);
            step();
            checkOutput($sformatf("press_tick_%0d", k + 1), {1'b0, sample_tick}, {1'b0, vecs[k].tick});
            checkOutput($sformatf("press_db_%0d", k + 1),   key_db,      vecs[k].db);
            checkOutput($sformatf("press_chg_%0d", k + 1),  key_changed, vecs[k].chg);
        end
        checkOutput("press_al_db", key_db_al, 2'b00);

        // Bounce on ch0 every 5 clocks for 40 clocks, then held pressed.
        doReset(2, 2'b01, 2'b11);
        pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            exp_db  = (k >= 53) ? 2'b01 : 2'b00;
            exp_chg = (k == 53) ? 2'b01 : 2'b00;
            checkOutput($sformatf("bounce_db_%0d", k),  key_db,      exp_db);
            checkOutput($sformatf("bounce_chg_%0d", k), key_changed, exp_chg);
            if (key_changed[0]) pulses++;
            if (k <= 40 && (k % 5) == 0) applyStimulus({1'b0, ((k / 5) % 2) == 0}, 2'b11);
        end
        checkOutput("bounce_pulses", 2'(pulses), 2'd1);

        // Active-low pins: pin0 pulled low, then released again.
        applyStimulus(2'b00, 2'b11);
        doReset(3, 2'b00, 2'b10);
        for (int k = 1; k <= 28; k++) begin
            step();
            exp_db  = (k >= 13 && k < 25) ? 2'b01 : 2'b00;
            exp_chg = (k == 13 || k == 25) ? 2'b01 : 2'b00;
            checkOutput($sformatf("al_db_%0d", k),  key_db_al,      exp_db);
            checkOutput($sformatf("al_chg_%0d", k), key_changed_al, exp_chg);
            if (k == 14) applyStimulus(2'b00, 2'b11);
        end

        // Reset after two differing ticks discards the partial count.
        doReset(2, 2'b01, 2'b11);
        for (int k = 1; k <= 9; k++) step();
        checkOutput("midcount_db_before", key_db, 2'b00);
        rst_n = 1'b0;
        #1;
        checkAllZero("midcount_reset");
        step();
        step();
        checkAllZero("midcount_held");
        rst_n = 1'b1;
        ticks  = 0;
        cycles = 0;
        while (key_db[0] !== 1'b1 && cycles < 100) begin
            if (sample_tick) ticks++;
            step();
            cycles++;
        end
        checkOutput("midcount_ticks", 2'(ticks), 2'd3);
        checkOutput("midcount_cycles_lo", cycles[1:0], 2'(13));
        checkOutput("midcount_cycles_hi", {1'b0, cycles == 13}, 2'b01);

        // Both keys change together, then both release together.
        doReset(2, 2'b11, 2'b11);
        for (int k = 1; k <= 26; k++) begin
            step();
            exp_db  = (k >= 13 && k < 25) ? 2'b11 : 2'b00;
            exp_chg = (k == 13 || k == 25) ? 2'b11 : 2'b00;
            checkOutput($sformatf("simul_db_%0d", k),  key_db,      exp_db);
            checkOutput($sformatf("simul_chg_%0d", k), key_changed, exp_chg);
            if (k == 14) applyStimulus(2'b00, 2'b11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
